// File: rtl/keypad_pkg.sv
// keypad_pkg: column state encoding, key map and frame-result encoding for the keypad scanner
package keypad_pkg;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] C0   = 3'd1;
  localparam logic [2:0] C1   = 3'd2;
  localparam logic [2:0] C2   = 3'd3;
  localparam logic [2:0] C3   = 3'd4;
  localparam logic [4:0] NONE = 5'b0_0000;
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };
endpackage

// File: rtl/keypad_scan_tick.sv
// scan_tick_gen: one-cycle tick every DIV cycles while enabled
// ports: clk, reset_n (async, active-low), enable (counter held at 0 when low), tick
module scan_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = enable && cnt_q == LAST;
    cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: scanned 4x4 keypad reader with frame debounce and ghost rejection
// ports: clk, reset_n (async, active-low), enable, row (active-low) in; col (one-hot-low), key_code, key_valid, key_held out
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS);
  if (DIV < 4) begin : g_div_check
    $error("keypad_scan: CLK_HZ/SCAN_HZ must be at least 4");
  end
  logic [3:0] row_m_q, row_s_q;
  logic [2:0] state_q, state_d;
  logic [2:0][3:0] rows_q, rows_d;
  logic [4:0] prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_next;
  logic [3:0] key_code_q, key_code_d;
  logic key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic tick, frame_done, same, reach, commit;
  logic [3:0][3:0] col_rows;
  logic [4:0] res, lows;
  scan_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable && state_q != IDLE),
    .tick   (tick)
  );
  always_comb begin
    state_d = !enable ? IDLE : state_q == IDLE ? C0 : !tick ? state_q : state_q == C3 ? C0 : state_q + 3'd1;
    col = state_q == C0 ? 4'b1110 : state_q == C1 ? 4'b1101 : state_q == C2 ? 4'b1011 : state_q == C3 ? 4'b0111 : 4'b1111;
    rows_d = rows_q;
    for (int c = 0; c < 3; c++) if (tick && state_q == 3'(c + 1)) rows_d[c] = row_s_q;
    // the C3 column is taken straight from the synchronizer on the completing tick
    col_rows = {row_s_q, rows_q};
    res = NONE;
    lows = '0;
    for (int i = 0; i < 16; i++)
      if (!col_rows[i % 4][i / 4]) begin
        lows = lows + 5'd1;
        res = {1'b1, KEY_MAP[i]};
      end
    if (lows != 5'd1) res = NONE;
    frame_done = tick && state_q == C3;
    same = res == prev_q;
    cnt_next = !same ? CW'(1) : cnt_q == DB_MAX ? DB_MAX : cnt_q + 1'b1;
    // only the first arrival at the threshold acts; a saturated repeat does not
    reach = cnt_next == DB_MAX && (cnt_q != DB_MAX || !same);
    commit = frame_done && reach && res[4] && (res[3:0] != key_code_q || !key_held_q);
    prev_d = !enable ? NONE : frame_done ? res : prev_q;
    cnt_d = !enable ? '0 : frame_done ? cnt_next : cnt_q;
    key_valid_d = commit;
    key_code_d = commit ? res[3:0] : key_code_q;
    key_held_d = !enable ? 1'b0 : (frame_done && reach) ? res[4] : key_held_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      row_m_q     <= 4'hF;
      row_s_q     <= 4'hF;
      state_q     <= IDLE;
      rows_q      <= '1;
      prev_q      <= NONE;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_m_q     <= row;
      row_s_q     <= row_m_q;
      state_q     <= state_d;
      rows_q      <= rows_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed frame-by-frame checks of the keypad scanner
module tb_keypad_scan;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic [3:0] row, col, key_code;
  logic key_valid, key_held;
  logic [15:0] keys = '0;
  int total = 0;
  int passed = 0;
  localparam logic [15:0] K5 = 16'h0020, K9 = 16'h0400, KGHOST = 16'h0041,
                          KA = 16'h0008, KD = 16'h8000, KE = 16'h4000, KF = 16'h2000;
  keypad_scan #(.CLK_HZ(16), .SCAN_HZ(4), .DEBOUNCE_SCANS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );
  always #5 clk = ~clk;
  // pressed switch at (r,c) pulls row r low while column c is strobed
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " col"}, col, 4'b1111);
    chk({tag, " code"}, key_code, 4'h0);
    chk({tag, " valid"}, {3'b0, key_valid}, 4'h0);
    chk({tag, " held"}, {3'b0, key_held}, 4'h0);
  endtask
  // enters and leaves on the first C0 cycle; key_valid seen on exit belongs to this frame
  task automatic frame(input string tag, input logic [15:0] k, input logic exp_kv,
                       input logic [3:0] exp_code, input logic exp_held);
    logic [3:0] ec;
    keys = k;
    for (int i = 0; i < 16; i++) begin
      ec = 4'b1111;
      ec[i / 4] = 1'b0;
      chk({tag, " col"}, col, ec);
      if (i > 0) chk({tag, " stray valid"}, {3'b0, key_valid}, 4'h0);
      @(negedge clk);
    end
    chk({tag, " valid"}, {3'b0, key_valid}, {3'b0, exp_kv});
    chk({tag, " code"}, key_code, exp_code);
    chk({tag, " held"}, {3'b0, key_held}, {3'b0, exp_held});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    frame("idle", '0, 1'b0, 4'h0, 1'b0);
    for (int f = 1; f <= 6; f++) frame("press5", K5, f == 4, f >= 4 ? 4'h5 : 4'h0, f >= 4);
    for (int f = 1; f <= 7; f++) frame("bounce9", f == 3 ? 16'h0 : K9, f == 7, f == 7 ? 4'h9 : 4'h5, 1'b1);
    for (int f = 1; f <= 8; f++) frame("ghost", KGHOST, 1'b0, 4'h9, f < 4);
    for (int f = 1; f <= 4; f++) frame("pressA", KA, f == 4, f == 4 ? 4'hA : 4'h9, f == 4);
    for (int f = 1; f <= 4; f++) frame("releaseA", '0, 1'b0, 4'hA, f < 4);
    for (int f = 1; f <= 4; f++) frame("pressD", KD, f == 4, f == 4 ? 4'hD : 4'hA, f == 4);
    for (int f = 1; f <= 4; f++) frame("changeE", KE, f == 4, f == 4 ? 4'hE : 4'hD, 1'b1);
    for (int f = 1; f <= 4; f++) frame("pressF", KF, f == 4, f == 4 ? 4'hF : 4'hE, 1'b1);
    repeat (9) @(negedge clk);
    chk("mid C2 col", col, 4'b1011);
    enable = 1'b0;
    @(negedge clk);
    chk("disable col", col, 4'b1111);
    chk("disable held", {3'b0, key_held}, 4'h0);
    chk("disable code", key_code, 4'hF);
    chk("disable valid", {3'b0, key_valid}, 4'h0);
    repeat (3) @(negedge clk);
    chk("disabled col", col, 4'b1111);
    enable = 1'b1;
    @(negedge clk);
    for (int f = 1; f <= 4; f++) frame("recommitF", KF, f == 4, 4'hF, f == 4);
    keys = KF;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    frame("restart", '0, 1'b0, 4'h0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
